pow2_interp_pipe: RTL and testbench
===================================

# pow2_interp_pipe

Parametrised, pipelined fractional power-of-two converter for the log-number datapath. It maps a fixed-point fraction x in [0,1) to (2^x − 1) in OUT_WIDTH fractional bits using a 2^SEG_BITS-segment table with linear interpolation. It replaces fixed-size pow2 lookup tables at the log-to-linear boundary (log-domain accumulate → linear conversion). The pipeline is three stages with valid/ready flow control and a sideband tag carried alongside each sample.

## Interface
- IN_WIDTH, 8: input fraction bits; x = in_data / 2^IN_WIDTH
- OUT_WIDTH, 12: output fraction bits; result = out_data / 2^OUT_WIDTH
- SEG_BITS, 4: table index bits; requires 1 ≤ SEG_BITS ≤ IN_WIDTH
- TAG_WIDTH, 8: sideband bits (e.g. sign/exponent) carried unmodified
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input sample present
- in_ready  out  1  pipeline accepts the sample this cycle
- in_data  in  IN_WIDTH  fraction x
- in_tag  in  TAG_WIDTH  sideband for this sample
- out_valid  out  1  result present
- out_ready  in  1  downstream consumes the result this cycle
- out_data  out  OUT_WIDTH  round((2^x − 1)·2^OUT_WIDTH), interpolated
- out_tag  out  TAG_WIDTH  in_tag of the same sample

## Operation
- Let F = IN_WIDTH − SEG_BITS, k = in_data[IN_WIDTH−1:F], and f = in_data[F−1:0]. When F = 0, f = 0.
- Table entries: T[j] = round-half-up((2^(j/2^SEG_BITS) − 1)·2^OUT_WIDTH) for j = 0..2^SEG_BITS.
  - Entries are OUT_WIDTH+1 bits wide.
  - T[2^SEG_BITS] = 2^OUT_WIDTH.
  - The table is elaborated as constants computed at elaboration time from the parameters. No runtime writes.
- Result: r = T[k] + (((T[k+1] − T[k])·f + 2^(F−1)) >> F).
  - When F = 0, r = T[k].
  - The delta is unsigned, OUT_WIDTH+1 bits wide. The product is OUT_WIDTH+1+F bits wide. No intermediate truncation.
- Saturation: if r ≥ 2^OUT_WIDTH, then out_data = 2^OUT_WIDTH − 1. Otherwise out_data = r[OUT_WIDTH−1:0].
- Stages:
  - S1 registers k, f, T[k], T[k+1], and tag.
  - S2 registers T[k], the product, and tag.
  - S3 registers the rounded sum with saturation applied, and tag. S3 drives out_*.
- Flow control: each stage has a valid bit v1..v3.
  - Stage n loads when it is empty or its contents advance this cycle.
  - S3 advances when out_ready.
  - S2 advances when !v3 or out_ready.
  - S1 advances when !v2 or S2 advances.
  - in_ready = !v1 or S1 advances. This is a combinational path from out_ready; that path is permitted.
- Bubbles collapse: an empty stage never stalls the stage upstream of it.
- A held result keeps out_data and out_tag stable while out_valid && !out_ready.
- The input is accepted iff in_valid && in_ready. No sample is dropped or duplicated. Samples leave in order.

## Timing
- Reset (clock edge with reset = 1):
  - v1 = v2 = v3 = 0, so out_valid = 0.
  - out_data = 0 and out_tag = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-stream discards every in-flight sample.
- Latency: a sample accepted at edge t appears with out_valid = 1 after edge t+2. It is visible in the cycle following that edge, i.e. the third cycle counting acceptance as cycle 1.
  - This holds when out_ready stayed high.
  - Each stalled S3 cycle adds one.
- Throughput: one sample per cycle while out_ready = 1.
- Full pipeline: with all three stages valid and out_ready = 0, in_ready = 0. Contents are held.
  - Raising out_ready gives in_ready = 1 in the same cycle.
  - The S1→S2→S3 shift and the new accept happen on the same edge.
- Simultaneous accept and drain on the same edge is a normal shift. Occupancy stays constant.
- in_valid while in_ready = 0 has no effect. The source must hold its data.

## Test plan
Default parameters apply throughout (8/12/4/8).
- Reset, then single samples with out_ready = 1:
  - in_data 0x00 → out_data 0.
  - 0x01 → 11.
  - 0x80 → 1697.
  - 0xFF → 4074.
  - Each arrives exactly 3 cycles after acceptance with its tag.
- Exhaustive sweep of all 256 inputs back-to-back, out_ready = 1:
  - One result per cycle after the 3-cycle fill.
  - Every out_data equals a bit-exact model of the formula.
  - Results are monotonic non-decreasing.
- Backpressure: stream tags 0..9, out_ready = 0 for cycles 3–8.
  - in_ready drops after the pipeline fills.
  - No tag is lost or repeated; order is 0..9.
  - out_data stays stable while stalled.
- Random in_valid (50%) and out_ready (30%), 10k samples:
  - The scoreboard matches in order.
  - A sample is accepted iff in_valid && in_ready.
- Assert reset with 3 samples in flight:
  - out_valid = 0 and out_data = 0 the next cycle.
  - No stale sample emerges afterwards.
- Parameter sweep at SEG_BITS = IN_WIDTH (pure table, F = 0) and at IN_WIDTH = 10, OUT_WIDTH = 16:
  - The model matches for all inputs.
  - Never saturates beyond 2^OUT_WIDTH − 1.

Source files
------------

// File: rtl/pow2_interp_pipe.sv
// Three-stage fractional 2^x - 1 converter: segment table plus linear interpolation,
// with valid/ready flow control and a sideband tag that travels alongside each sample.
module pow2_interp_pipe #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 12,
    parameter int SEG_BITS  = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int NSEG = 1 << SEG_BITS;
    localparam int F    = IN_WIDTH - SEG_BITS;
    localparam int FW   = (F > 0) ? F : 1;
    localparam int TW   = OUT_WIDTH + 1;
    localparam int PW   = TW + FW;
    localparam int SW   = OUT_WIDTH + 2;
    localparam int KW   = SEG_BITS + 1;

    // exp(x*ln2) by Taylor series; 30 terms is far below one output LSB of error for x <= 1
    function automatic logic [TW-1:0] pow2_entry(input int j);
        real x;
        real term;
        real acc;
        real scale;
        x     = (real'(j) / real'(NSEG)) * 0.6931471805599453;
        term  = 1.0;
        acc   = 1.0;
        scale = 1.0;
        for (int n = 1; n < 30; n++) begin
            term = term * x / real'(n);
            acc  = acc + term;
        end
        for (int n = 0; n < OUT_WIDTH; n++) begin
            scale = scale * 2.0;
        end
        return TW'($rtoi((acc - 1.0) * scale + 0.5));
    endfunction

    logic [TW-1:0] w_table [0:NSEG];

    genvar gi;
    generate
        for (gi = 0; gi <= NSEG; gi++) begin : g_table
            if (gi == NSEG) begin : g_top
                assign w_table[gi] = TW'(1) << OUT_WIDTH;
            end else begin : g_entry
                localparam logic [TW-1:0] ENTRY = pow2_entry(gi);
                assign w_table[gi] = ENTRY;
            end
        end
    endgenerate

    logic [KW-1:0]        w_k0;
    logic [KW-1:0]        w_k1;
    logic [FW-1:0]        w_f;
    logic [TW-1:0]        w_delta;
    logic [PW-1:0]        w_prod;
    logic [SW-1:0]        w_inc;
    logic [SW-1:0]        w_sum;
    logic [OUT_WIDTH-1:0] w_sat;
    logic                 w_s1_adv;
    logic                 w_s2_adv;

    logic                 r1_valid;
    logic [FW-1:0]        r1_f;
    logic [TW-1:0]        r1_tk;
    logic [TW-1:0]        r1_tk1;
    logic [TAG_WIDTH-1:0] r1_tag;
    logic                 r2_valid;
    logic [TW-1:0]        r2_tk;
    logic [PW-1:0]        r2_prod;
    logic [TAG_WIDTH-1:0] r2_tag;
    logic                 r3_valid;
    logic [OUT_WIDTH-1:0] r3_data;
    logic [TAG_WIDTH-1:0] r3_tag;

    assign w_k0 = {1'b0, in_data[IN_WIDTH-1:F]};
    assign w_k1 = w_k0 + KW'(1);

    // With no fraction bits f is tied to zero, so the product is zero and r = T[k]
    generate
        if (F > 0) begin : g_frac
            localparam logic [PW-1:0] HALF = PW'(1) << (F - 1);
            assign w_f   = in_data[F-1:0];
            assign w_inc = SW'((r2_prod + HALF) >> F);
        end else begin : g_nofrac
            assign w_f   = '0;
            assign w_inc = SW'(r2_prod);
        end
    endgenerate

    assign w_delta = r1_tk1 - r1_tk;
    assign w_prod  = PW'(w_delta) * PW'(r1_f);
    assign w_sum   = SW'(r2_tk) + w_inc;
    assign w_sat   = (w_sum >= (SW'(1) << OUT_WIDTH)) ? '1 : w_sum[OUT_WIDTH-1:0];

    // Each stage loads when empty or when its contents move on this cycle
    assign w_s2_adv  = !r3_valid || out_ready;
    assign w_s1_adv  = !r2_valid || w_s2_adv;
    assign in_ready  = !r1_valid || w_s1_adv;

    always_ff @(posedge clock) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_f     <= '0;
            r1_tk    <= '0;
            r1_tk1   <= '0;
            r1_tag   <= '0;
            r2_valid <= 1'b0;
            r2_tk    <= '0;
            r2_prod  <= '0;
            r2_tag   <= '0;
            r3_valid <= 1'b0;
            r3_data  <= '0;
            r3_tag   <= '0;
        end else begin
            if (in_ready) begin
                r1_valid <= in_valid;
                if (in_valid) begin
                    r1_f   <= w_f;
                    r1_tk  <= w_table[w_k0];
                    r1_tk1 <= w_table[w_k1];
                    r1_tag <= in_tag;
                end
            end
            if (w_s1_adv) begin
                r2_valid <= r1_valid;
                if (r1_valid) begin
                    r2_tk   <= r1_tk;
                    r2_prod <= w_prod;
                    r2_tag  <= r1_tag;
                end
            end
            if (w_s2_adv) begin
                r3_valid <= r2_valid;
                if (r2_valid) begin
                    r3_data <= w_sat;
                    r3_tag  <= r2_tag;
                end
            end
        end
    end

    assign out_valid = r3_valid;
    assign out_data  = r3_data;
    assign out_tag   = r3_tag;

endmodule

// File: tb/tb_pow2_interp_pipe.sv
// Directed and scoreboarded bench for pow2_interp_pipe: default instance plus two
// alternate parameter sets (pure table, and 10-in/16-out).
module tb_pow2_interp_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic [7:0]  out_tag;

    logic        f_in_valid = 1'b0;
    logic        f_in_ready;
    logic [7:0]  f_in_data = '0;
    logic        f_out_valid;
    logic [11:0] f_out_data;
    logic [7:0]  f_out_tag;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [9:0]  w_in_data = '0;
    logic        w_out_valid;
    logic [15:0] w_out_data;
    logic [7:0]  w_out_tag;

    always #5 clock = ~clock;

    pow2_interp_pipe u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    pow2_interp_pipe #(.IN_WIDTH(8), .OUT_WIDTH(12), .SEG_BITS(8), .TAG_WIDTH(8)) u_f0 (
        .clock(clock), .reset(reset),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data), .in_tag(f_in_data),
        .out_valid(f_out_valid), .out_ready(1'b1), .out_data(f_out_data), .out_tag(f_out_tag)
    );

    pow2_interp_pipe #(.IN_WIDTH(10), .OUT_WIDTH(16), .SEG_BITS(4), .TAG_WIDTH(8)) u_wide (
        .clock(clock), .reset(reset),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_tag(w_in_data[7:0]),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data), .out_tag(w_out_tag)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic longint table_val(input int j, input int sb, input int ow);
        if (j == (1 << sb)) return longint'(1) << ow;
        return longint'($rtoi((2.0 ** (real'(j) / real'(1 << sb)) - 1.0) * real'(1 << ow) + 0.5));
    endfunction

    function automatic longint model(input int x, input int iw, input int ow, input int sb);
        int     fb;
        int     k;
        longint f;
        longint t0;
        longint t1;
        longint r;
        fb = iw - sb;
        k  = x >> fb;
        f  = (fb > 0) ? longint'(x & ((1 << fb) - 1)) : 0;
        t0 = table_val(k, sb, ow);
        t1 = table_val(k + 1, sb, ow);
        if (fb == 0) r = t0;
        else         r = t0 + (((t1 - t0) * f + (longint'(1) << (fb - 1))) >> fb);
        if (r >= (longint'(1) << ow)) r = (longint'(1) << ow) - 1;
        return r;
    endfunction

    typedef struct {
        int d;
        int tag;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc_n = 0;
    int   n_out = 0;
    int   last_data = 0;
    int   last_tag = 0;
    int   last_lat = 0;
    bit   lat_en = 0;
    bit   mono_en = 0;
    int   prev_mono = 0;
    bit   prev_stall = 0;
    int   prev_d = 0;
    int   prev_t = 0;
    bit   last_acc = 0;
    bit   saw_block = 0;

    int sd [4] = '{0, 1, 128, 255};
    int se [4] = '{0, 11, 1697, 4074};

    // One clock of the default instance: drive at the falling edge, observe 1 ns later.
    task automatic cycle(input bit v, input int d, input int tag, input bit ordy);
        exp_t e;
        exp_t n;
        @(negedge clock);
        in_valid  = v;
        in_data   = d[7:0];
        in_tag    = tag[7:0];
        out_ready = ordy;
        #1;
        cyc_n++;
        if (prev_stall) begin
            check_value("hold_valid", longint'(out_valid), 1);
            check_value("hold_data", longint'(out_data), prev_d);
            check_value("hold_tag", longint'(out_tag), prev_t);
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = int'(out_data);
        prev_t     = int'(out_tag);
        if (!in_ready) saw_block = 1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check_value("sb_underflow", q.size(), 1);
            end else begin
                e = q.pop_front();
                check_value("sb_data", longint'(out_data), e.d);
                check_value("sb_tag", longint'(out_tag), e.tag);
                last_data = int'(out_data);
                last_tag  = int'(out_tag);
                last_lat  = cyc_n - e.cyc;
                if (lat_en) check_value("latency", last_lat, 3);
                if (mono_en) begin
                    check_value("monotonic", longint'(int'(out_data) >= prev_mono), 1);
                    prev_mono = int'(out_data);
                end
            end
            n_out++;
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            n.d   = int'(model(d & 255, 8, 12, 4));
            n.tag = tag & 255;
            n.cyc = cyc_n;
            q.push_back(n);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int nxt;
        int acc;
        int guard;
        bit pv;
        bit pend;
        int pd;
        int pt;
        int nf;
        int nw;
        int x;
        int qf[$];
        int qw[$];

        // reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_value("reset_out_valid", longint'(out_valid), 0);
        check_value("reset_out_data", longint'(out_data), 0);
        check_value("reset_out_tag", longint'(out_tag), 0);
        check_value("reset_in_ready", longint'(in_ready), 1);

        // isolated samples with hand-computed results
        for (int i = 0; i < 4; i++) begin
            n0 = n_out;
            cycle(1, sd[i], 8'hA0 + i, 1);
            for (int c = 0; c < 8 && n_out == n0; c++) cycle(0, 0, 0, 1);
            check_value("single_seen", n_out - n0, 1);
            check_value("single_data", last_data, se[i]);
            check_value("single_tag", last_tag, 8'hA0 + i);
            check_value("single_lat", last_lat, 3);
        end

        // exhaustive back-to-back sweep
        lat_en = 1; mono_en = 1; prev_mono = 0;
        n0 = n_out; acc = 0;
        for (int i = 0; i < 256; i++) begin
            cycle(1, i, i ^ 8'h5A, 1);
            if (last_acc) acc++;
        end
        for (int c = 0; c < 5; c++) cycle(0, 0, 0, 1);
        lat_en = 0; mono_en = 0;
        check_value("sweep_accepts", acc, 256);
        check_value("sweep_outputs", n_out - n0, 256);

        // backpressure: out_ready low for cycles 3..8
        n0 = n_out; saw_block = 0; nxt = 0;
        for (int c = 1; c <= 40; c++) begin
            cycle(nxt < 10, nxt * 25, nxt, !(c >= 3 && c <= 8));
            if (last_acc) nxt++;
        end
        check_value("bp_outputs", n_out - n0, 10);
        check_value("bp_in_ready_dropped", saw_block, 1);
        check_value("bp_last_tag", last_tag, 9);
        check_value("bp_queue_empty", q.size(), 0);

        // random valid/ready traffic
        n0 = n_out; acc = 0; guard = 0; pend = 0; pv = 0; pd = 0; pt = 0;
        while (acc < 10000 && guard < 60000) begin
            if (!pend) begin
                pv = ($urandom_range(0, 1) == 1);
                pd = int'($urandom_range(0, 255));
                pt = int'($urandom_range(0, 255));
            end
            cycle(pv, pd, pt, $urandom_range(0, 99) < 30);
            pend = pv && !last_acc;
            if (last_acc) acc++;
            guard++;
        end
        for (int c = 0; c < 10; c++) cycle(0, 0, 0, 1);
        check_value("rand_accepts", acc, 10000);
        check_value("rand_outputs", n_out - n0, 10000);
        check_value("rand_queue_empty", q.size(), 0);

        // reset with three samples in flight
        for (int i = 0; i < 3; i++) cycle(1, 200 + i, 8'h30 + i, 0);
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        #1;
        check_value("midreset_out_valid", longint'(out_valid), 0);
        check_value("midreset_out_data", longint'(out_data), 0);
        reset = 1'b0;
        q.delete();
        prev_stall = 0;
        n0 = n_out;
        for (int c = 0; c < 10; c++) cycle(0, 0, 0, 1);
        check_value("midreset_no_stale", n_out - n0, 0);

        // alternate parameter sets, full input sweeps
        nf = 0; nw = 0;
        for (int i = 0; i < 1030; i++) begin
            @(negedge clock);
            f_in_valid = (i < 256);
            f_in_data  = i[7:0];
            w_in_valid = (i < 1024);
            w_in_data  = i[9:0];
            #1;
            if (f_out_valid) begin
                if (qf.size() == 0) check_value("f0_underflow", qf.size(), 1);
                else begin
                    x = qf.pop_front();
                    check_value("f0_data", longint'(f_out_data), model(x, 8, 12, 8));
                    check_value("f0_tag", longint'(f_out_tag), x & 255);
                    nf++;
                end
            end
            if (w_out_valid) begin
                if (qw.size() == 0) check_value("wide_underflow", qw.size(), 1);
                else begin
                    x = qw.pop_front();
                    check_value("wide_data", longint'(w_out_data), model(x, 10, 16, 4));
                    check_value("wide_tag", longint'(w_out_tag), x & 255);
                    nw++;
                end
            end
            if (f_in_valid && f_in_ready) qf.push_back(i);
            if (w_in_valid && w_in_ready) qw.push_back(i);
        end
        check_value("f0_outputs", nf, 256);
        check_value("wide_outputs", nw, 1024);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
